ga_gen_controller: RTL and testbench
====================================

GA_GEN_CONTROLLER -- requirements
Module: ga_gen_controller

Interface
REQ-001 Parameter N_GEN, default 16, number of select+mutate generations per run (1..2^GEN_W-1).
REQ-002 Parameter GEN_W, default 8, width of generation counter.
REQ-003 Parameter SEED_W, default 32, width of free-running seed counter.
REQ-004 Parameter TIMEOUT, default 1024, max cycles per phase (used only with GA_TIMEOUT_EN).
REQ-005 Interface SHALL be: one clock; reset is asynchronous and active-low.
REQ-006 clk  in  1  rising-edge clock.
REQ-007 rst_n  in  1  asynchronous active-low reset.
REQ-008 start  in  1  run request, sampled high for one cycle.
REQ-009 abort  in  1  cancel current run.
REQ-010 init_done / sel_done / mut_done  in  1 each  sub-block completion pulses.
REQ-011 init_start / sel_start / mut_start  out  1 each  one-cycle sub-block start pulses.
REQ-012 pop_load_init / pop_load_mut  out  1 each  one-cycle population-register load strobes.
REQ-013 seed  out  SEED_W  free-running PRNG seed.
REQ-014 gen_count  out  GEN_W  completed generations in current run.
REQ-015 busy  out  1  high in INIT, SEL, MUT.
REQ-016 done  out  1  high while in DONE.
REQ-017 error  out  1  sticky phase-timeout flag.

Function
REQ-018 States SHALL be IDLE, INIT, SEL, MUT, DONE; all outputs registered.
REQ-019 start high in IDLE or DONE: next cycle enter INIT, clear gen_count and error, pulse init_start that cycle.
REQ-020 start while busy SHALL be ignored.
REQ-021 INIT + init_done: pulse pop_load_init, enter SEL, pulse sel_start in the same registered cycle.
REQ-022 SEL + sel_done: enter MUT, pulse mut_start.
REQ-023 MUT + mut_done: pulse pop_load_mut, increment gen_count; if new gen_count == N_GEN enter DONE, else enter SEL and pulse sel_start.
REQ-024 Latency: each phase transition one cycle after the sampled done pulse; no idle cycles between generations.
REQ-025 A done input not matching the current phase SHALL be ignored.
REQ-026 abort high in INIT/SEL/MUT/DONE: next cycle IDLE, no strobes, gen_count held; abort beats a coincident done input and a coincident start.
REQ-027 seed SHALL increment by 1 every cycle, wrapping from 2^SEED_W-1 to 0, independent of state.
REQ-028 DONE SHALL hold done=1 and gen_count=N_GEN until start or abort.

Reset
REQ-029 rst_n low SHALL immediately force IDLE, seed=0, gen_count=0, all strobes 0, busy=0, done=0, error=0.
REQ-030 Reset mid-run SHALL discard the run; no strobe emitted during or on the cycle after deassertion.

Configuration
REQ-031 With GA_TIMEOUT_EN defined: phase counter restarts on each phase entry; reaching TIMEOUT cycles in INIT/SEL/MUT without the matching done SHALL force IDLE and set error=1, held until next start.
REQ-032 Without GA_TIMEOUT_EN: phases wait indefinitely; error tied 0; no phase counter logic.

Structure
REQ-033 Package ga_pkg SHALL hold the state enum, PATH_W=150, POP_PATHS=50, SEL_PATHS=10 and the derived population widths.
REQ-034 Phase counter SHALL be sub-module ga_phase_timer, instantiated only under GA_TIMEOUT_EN.

Verification
REQ-035 N_GEN=3, start, each done returned 2 cycles after its start: exactly 1 init_start, 3 sel_start, 3 mut_start, 3 pop_load_mut; done=1, gen_count=3.
REQ-036 start pulsed during SEL of gen 1: ignored; run still ends with gen_count=3 and no extra init_start.
REQ-037 abort coincident with mut_done in gen 2: IDLE next cycle, no pop_load_mut, gen_count=1, done=0.
REQ-038 sel_done asserted during INIT: no transition; SEL entered only after init_done.
REQ-039 GA_TIMEOUT_EN, TIMEOUT=8, mut_done never returned: IDLE and error=1 after 8 MUT cycles; next start clears error.
REQ-040 rst_n low for 3 cycles mid-MUT then released: all outputs 0, seed counts 0,1,2 after release.

Source files
------------

// File: rtl/ga_pkg.sv
// rtl/ga_pkg.sv - shared state encoding and population geometry for the GA generation controller
package ga_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    SEL,
    MUT,
    DONE
  } ga_state_e;

  localparam int PATH_W    = 150;
  localparam int POP_PATHS = 50;
  localparam int SEL_PATHS = 10;
  localparam int POP_W     = PATH_W * POP_PATHS;
  localparam int SEL_W     = PATH_W * SEL_PATHS;

  function automatic logic is_phase(input ga_state_e s);
    return (s == INIT) || (s == SEL) || (s == MUT);
  endfunction

endpackage

// File: rtl/ga_gen_controller_if.sv
// rtl/ga_gen_controller_if.sv - run control, sub-block handshakes and status of the GA controller
interface ga_gen_controller_if #(
  parameter int SEED_W = 32,
  parameter int GEN_W  = 8
);
  logic              start;
  logic              abort;
  logic              init_done;
  logic              sel_done;
  logic              mut_done;
  logic              init_start;
  logic              sel_start;
  logic              mut_start;
  logic              pop_load_init;
  logic              pop_load_mut;
  logic [SEED_W-1:0] seed;
  logic [GEN_W-1:0]  gen_count;
  logic              busy;
  logic              done;
  logic              error;

  modport master (
    output start, abort, init_done, sel_done, mut_done,
    input  init_start, sel_start, mut_start, pop_load_init, pop_load_mut,
    input  seed, gen_count, busy, done, error
  );

  modport slave (
    input  start, abort, init_done, sel_done, mut_done,
    output init_start, sel_start, mut_start, pop_load_init, pop_load_mut,
    output seed, gen_count, busy, done, error
  );
endinterface

// File: rtl/ga_phase_timer.sv
// rtl/ga_phase_timer.sv - per-phase cycle counter; flags the last allowed cycle of a phase
module ga_phase_timer #(
  parameter int TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic restart,
  output logic expired
);
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (restart || !run) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // cnt_q is 0 in the first cycle of a phase, so TIMEOUT-1 marks the TIMEOUT-th cycle
  assign expired = run && (cnt_q == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/ga_gen_controller.sv
// rtl/ga_gen_controller.sv - GA run sequencer INIT -> (SEL -> MUT) x N_GEN -> DONE; GA_TIMEOUT_EN adds phase timeout
module ga_gen_controller #(
  parameter int N_GEN   = 16,
  parameter int GEN_W   = 8,
  parameter int SEED_W  = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  ga_gen_controller_if.slave bus
);
  import ga_pkg::*;

  ga_state_e         state_q, state_d;
  logic [GEN_W-1:0]  gen_q, gen_d, gen_inc;
  logic [SEED_W-1:0] seed_q;
  logic init_start_q, sel_start_q, mut_start_q, ld_init_q, ld_mut_q, busy_q, done_q;
  logic init_start_d, sel_start_d, mut_start_d, ld_init_d, ld_mut_d, busy_d, done_d;

`ifdef GA_TIMEOUT_EN
  logic expired;
  logic timeout_hit;
  logic err_q;
`endif

  always_comb begin
    state_d      = state_q;
    gen_d        = gen_q;
    gen_inc      = gen_q + GEN_W'(1);
    init_start_d = 1'b0;
    sel_start_d  = 1'b0;
    mut_start_d  = 1'b0;
    ld_init_d    = 1'b0;
    ld_mut_d     = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (state_q == DONE && bus.abort) begin
          state_d = IDLE;
        end else if (bus.start) begin
          state_d      = INIT;
          gen_d        = '0;
          init_start_d = 1'b1;
        end
      end
      INIT: begin
        if (bus.abort) begin
          state_d = IDLE;
        end else if (bus.init_done) begin
          state_d     = SEL;
          ld_init_d   = 1'b1;
          sel_start_d = 1'b1;
        end
      end
      SEL: begin
        if (bus.abort) begin
          state_d = IDLE;
        end else if (bus.sel_done) begin
          state_d     = MUT;
          mut_start_d = 1'b1;
        end
      end
      MUT: begin
        if (bus.abort) begin
          state_d = IDLE;
        end else if (bus.mut_done) begin
          ld_mut_d = 1'b1;
          gen_d    = gen_inc;
          if (gen_inc == GEN_W'(N_GEN)) begin
            state_d = DONE;
          end else begin
            state_d     = SEL;
            sel_start_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
`ifdef GA_TIMEOUT_EN
    // a phase that is neither completing nor aborting on its last allowed cycle gives up
    timeout_hit = expired && (state_d == state_q);
    if (timeout_hit) begin
      state_d = IDLE;
    end
`endif
    busy_d = is_phase(state_d);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      gen_q        <= '0;
      seed_q       <= '0;
      init_start_q <= 1'b0;
      sel_start_q  <= 1'b0;
      mut_start_q  <= 1'b0;
      ld_init_q    <= 1'b0;
      ld_mut_q     <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      gen_q        <= gen_d;
      seed_q       <= seed_q + SEED_W'(1);
      init_start_q <= init_start_d;
      sel_start_q  <= sel_start_d;
      mut_start_q  <= mut_start_d;
      ld_init_q    <= ld_init_d;
      ld_mut_q     <= ld_mut_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

`ifdef GA_TIMEOUT_EN
  ga_phase_timer #(.TIMEOUT(TIMEOUT)) u_phase_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .run     (is_phase(state_q)),
    .restart (state_d != state_q),
    .expired (expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (init_start_d) begin
      err_q <= 1'b0;
    end else if (timeout_hit) begin
      err_q <= 1'b1;
    end
  end

  assign bus.error = err_q;
`else
  assign bus.error = 1'b0;
`endif

  assign bus.init_start    = init_start_q;
  assign bus.sel_start     = sel_start_q;
  assign bus.mut_start     = mut_start_q;
  assign bus.pop_load_init = ld_init_q;
  assign bus.pop_load_mut  = ld_mut_q;
  assign bus.seed          = seed_q;
  assign bus.gen_count     = gen_q;
  assign bus.busy          = busy_q;
  assign bus.done          = done_q;

endmodule

// File: tb/tb_ga_gen_controller.sv
// tb/tb_ga_gen_controller.sv - self-checking bench for ga_gen_controller with randomized sub-block response delays
module tb_ga_gen_controller;
  localparam int N_GEN   = 3;
  localparam int GEN_W   = 8;
  localparam int SEED_W  = 32;
  localparam int TIMEOUT = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_cmp = 0;
  int n_fail = 0;
  int c_init = 0, c_sel = 0, c_mut = 0, c_ldi = 0, c_ldm = 0;

  ga_gen_controller_if #(.SEED_W(SEED_W), .GEN_W(GEN_W)) bus ();

  ga_gen_controller #(
    .N_GEN(N_GEN), .GEN_W(GEN_W), .SEED_W(SEED_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (bus.init_start)    c_init++;
    if (bus.sel_start)     c_sel++;
    if (bus.mut_start)     c_mut++;
    if (bus.pop_load_init) c_ldi++;
    if (bus.pop_load_mut)  c_ldm++;
  end

  function automatic logic [12+GEN_W-1:0] all_outs();
    return {bus.init_start, bus.sel_start, bus.mut_start, bus.pop_load_init, bus.pop_load_mut,
            bus.busy, bus.done, bus.error, 4'b0, bus.gen_count};
  endfunction

  task automatic wait_rand(input bit fixed);
    int d;
    d = fixed ? 2 : int'($urandom_range(0, 3));
    repeat (d) @(negedge clk);
  endtask

  // one complete run; abort_gen>0 aborts together with that generation's mut_done
  task automatic test_run(input int abort_gen, input bit start_in_sel, input bit sel_in_init, input bit fixed);
    int b_i = c_init, b_s = c_sel, b_m = c_mut, b_li = c_ldi, b_lm = c_ldm;
    int g_model = 0;
    int exp_ph;
    bit aborted = 1'b0;
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    n_cmp++; if ({bus.init_start, bus.busy, bus.done} !== 3'b110) begin n_fail++; $display("FAIL run_init_start: got %b want 110", {bus.init_start, bus.busy, bus.done}); end
    n_cmp++; if (bus.gen_count !== '0) begin n_fail++; $display("FAIL run_gen_clear: got %0d want 0", bus.gen_count); end
    if (sel_in_init) begin
      bus.sel_done = 1'b1;
      @(negedge clk);
      bus.sel_done = 1'b0;
      n_cmp++; if ({bus.sel_start, bus.mut_start, bus.busy} !== 3'b001) begin n_fail++; $display("FAIL wrong_done_init: got %b want 001", {bus.sel_start, bus.mut_start, bus.busy}); end
    end
    wait_rand(fixed);
    bus.init_done = 1'b1;
    @(negedge clk);
    bus.init_done = 1'b0;
    n_cmp++; if ({bus.sel_start, bus.pop_load_init} !== 2'b11) begin n_fail++; $display("FAIL run_enter_sel: got %b want 11", {bus.sel_start, bus.pop_load_init}); end
    for (int g = 1; g <= N_GEN; g++) begin
      if (g == 1 && start_in_sel) begin
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        n_cmp++; if ({bus.init_start, bus.busy} !== 2'b01) begin n_fail++; $display("FAIL start_ignored: got %b want 01", {bus.init_start, bus.busy}); end
      end
      wait_rand(fixed);
      bus.sel_done = 1'b1;
      @(negedge clk);
      bus.sel_done = 1'b0;
      n_cmp++; if ({bus.mut_start, bus.sel_start} !== 2'b10) begin n_fail++; $display("FAIL run_enter_mut g%0d: got %b want 10", g, {bus.mut_start, bus.sel_start}); end
      wait_rand(fixed);
      if (g == abort_gen) begin
        bus.mut_done = 1'b1;
        bus.abort = 1'b1;
        @(negedge clk);
        bus.mut_done = 1'b0;
        bus.abort = 1'b0;
        n_cmp++; if ({bus.busy, bus.done, bus.pop_load_mut, bus.sel_start} !== 4'b0000) begin n_fail++; $display("FAIL abort_idle: got %b want 0000", {bus.busy, bus.done, bus.pop_load_mut, bus.sel_start}); end
        n_cmp++; if (bus.gen_count !== GEN_W'(g_model)) begin n_fail++; $display("FAIL abort_gen_held: got %0d want %0d", bus.gen_count, g_model); end
        @(negedge clk);
        n_cmp++; if ({bus.busy, bus.sel_start, bus.mut_start} !== 3'b000) begin n_fail++; $display("FAIL abort_stays_idle: got %b want 000", {bus.busy, bus.sel_start, bus.mut_start}); end
        aborted = 1'b1;
        break;
      end
      bus.mut_done = 1'b1;
      @(negedge clk);
      bus.mut_done = 1'b0;
      g_model++;
      n_cmp++; if ({bus.pop_load_mut, bus.gen_count} !== {1'b1, GEN_W'(g_model)}) begin n_fail++; $display("FAIL run_gen_done g%0d: got ld=%b gen=%0d want ld=1 gen=%0d", g, bus.pop_load_mut, bus.gen_count, g_model); end
      exp_ph = (g_model == N_GEN) ? 3'b010 : 3'b101;
      n_cmp++; if ({bus.sel_start, bus.done, bus.busy} !== 3'(exp_ph)) begin n_fail++; $display("FAIL run_next_phase g%0d: got %b want %b", g, {bus.sel_start, bus.done, bus.busy}, 3'(exp_ph)); end
    end
    if (!aborted) begin
      repeat (3) @(negedge clk);
      n_cmp++; if ({bus.done, bus.busy, bus.gen_count} !== {2'b10, GEN_W'(N_GEN)}) begin n_fail++; $display("FAIL done_hold: got done=%b busy=%b gen=%0d want 1 0 %0d", bus.done, bus.busy, bus.gen_count, N_GEN); end
    end
    n_cmp++; if (c_init - b_i !== 1) begin n_fail++; $display("FAIL cnt_init_start: got %0d want 1", c_init - b_i); end
    n_cmp++; if (c_ldi - b_li !== 1) begin n_fail++; $display("FAIL cnt_pop_load_init: got %0d want 1", c_ldi - b_li); end
    n_cmp++; if (c_sel - b_s !== (aborted ? abort_gen : N_GEN)) begin n_fail++; $display("FAIL cnt_sel_start: got %0d want %0d", c_sel - b_s, aborted ? abort_gen : N_GEN); end
    n_cmp++; if (c_mut - b_m !== (aborted ? abort_gen : N_GEN)) begin n_fail++; $display("FAIL cnt_mut_start: got %0d want %0d", c_mut - b_m, aborted ? abort_gen : N_GEN); end
    n_cmp++; if (c_ldm - b_lm !== (aborted ? abort_gen - 1 : N_GEN)) begin n_fail++; $display("FAIL cnt_pop_load_mut: got %0d want %0d", c_ldm - b_lm, aborted ? abort_gen - 1 : N_GEN); end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_cmp++; if (all_outs() !== '0 || bus.seed !== '0) begin n_fail++; $display("FAIL reset_state: got %h seed %0d want 0", all_outs(), bus.seed); end
    rst_n = 1'b1;
  endtask

  task automatic test_seed();
    logic [SEED_W-1:0] s, exp_s;
    int k;
    s = bus.seed;
    k = int'($urandom_range(1, 40));
    repeat (k) @(negedge clk);
    exp_s = s + SEED_W'(k);
    n_cmp++; if (bus.seed !== exp_s) begin n_fail++; $display("FAIL seed_count: got %0d want %0d", bus.seed, exp_s); end
  endtask

  task automatic test_done_exit();
    test_run(0, 1'b0, 1'b0, 1'b0);
    bus.start = 1'b1;
    bus.abort = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.abort = 1'b0;
    n_cmp++; if ({bus.busy, bus.done, bus.init_start} !== 3'b000) begin n_fail++; $display("FAIL done_abort_start: got %b want 000", {bus.busy, bus.done, bus.init_start}); end
    n_cmp++; if (bus.gen_count !== GEN_W'(N_GEN)) begin n_fail++; $display("FAIL done_abort_gen: got %0d want %0d", bus.gen_count, N_GEN); end
  endtask

  task automatic enter_mut(input int phase_wait);
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (phase_wait) @(negedge clk);
    bus.init_done = 1'b1;
    @(negedge clk);
    bus.init_done = 1'b0;
    repeat (phase_wait) @(negedge clk);
    bus.sel_done = 1'b1;
    @(negedge clk);
    bus.sel_done = 1'b0;
  endtask

`ifdef GA_TIMEOUT_EN
  task automatic test_timeout();
    enter_mut(5);
    n_cmp++; if ({bus.mut_start, bus.busy, bus.error} !== 3'b110) begin n_fail++; $display("FAIL to_mut_entry: got %b want 110", {bus.mut_start, bus.busy, bus.error}); end
    repeat (TIMEOUT - 1) @(negedge clk);
    n_cmp++; if ({bus.busy, bus.error} !== 2'b10) begin n_fail++; $display("FAIL to_last_cycle: got %b want 10", {bus.busy, bus.error}); end
    @(negedge clk);
    n_cmp++; if ({bus.busy, bus.error, bus.pop_load_mut} !== 3'b010) begin n_fail++; $display("FAIL to_expire: got %b want 010", {bus.busy, bus.error, bus.pop_load_mut}); end
    repeat (2) @(negedge clk);
    n_cmp++; if (bus.error !== 1'b1) begin n_fail++; $display("FAIL to_sticky: got %b want 1", bus.error); end
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    n_cmp++; if ({bus.error, bus.init_start} !== 2'b01) begin n_fail++; $display("FAIL to_clear: got %b want 01", {bus.error, bus.init_start}); end
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
  endtask
`else
  task automatic test_no_timeout();
    enter_mut(5);
    repeat (3 * TIMEOUT) @(negedge clk);
    n_cmp++; if ({bus.busy, bus.error, bus.done} !== 3'b100) begin n_fail++; $display("FAIL no_timeout_wait: got %b want 100", {bus.busy, bus.error, bus.done}); end
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
  endtask
`endif

  task automatic test_reset_mid_run();
    enter_mut(1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_cmp++; if (all_outs() !== '0 || bus.seed !== '0) begin n_fail++; $display("FAIL reset_async: got %h seed %0d want 0", all_outs(), bus.seed); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_cmp++; if (all_outs() !== '0 || bus.seed !== '0) begin n_fail++; $display("FAIL reset_release: got %h seed %0d want 0", all_outs(), bus.seed); end
    for (int i = 1; i <= 2; i++) begin
      @(negedge clk);
      n_cmp++; if (all_outs() !== '0 || bus.seed !== SEED_W'(i)) begin n_fail++; $display("FAIL reset_after_%0d: got %h seed %0d want 0 seed %0d", i, all_outs(), bus.seed, i); end
    end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.init_done = 1'b0;
    bus.sel_done = 1'b0;
    bus.mut_done = 1'b0;
    test_reset();
    test_seed();
    test_run(0, 1'b0, 1'b0, 1'b1);
    for (int r = 0; r < 3; r++) test_run(0, 1'b0, 1'b0, 1'b0);
    test_run(0, 1'b1, 1'b0, 1'b0);
    test_run(0, 1'b0, 1'b1, 1'b0);
    test_run(2, 1'b0, 1'b0, 1'b0);
    test_done_exit();
`ifdef GA_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    test_reset_mid_run();
    test_seed();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
